// File: rtl/seq_pd_pkg.sv
// Shared constants and elaboration helpers for the serial bit-pattern detector.
package seq_pd_pkg;

    localparam int LEN_MIN   = 2;
    localparam int LEN_MAX   = 32;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 16;

    function automatic int fill_width(input int len);
        return $clog2(len + 1);
    endfunction

    function automatic bit len_ok(input int len);
        return (len >= LEN_MIN) && (len <= LEN_MAX);
    endfunction

    function automatic bit cnt_w_ok(input int w);
        return (w >= CNT_W_MIN) && (w <= CNT_W_MAX);
    endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_r;

    // Count state: clear wins over increment, increment stops at the ceiling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector over a LEN-bit history window with runtime pattern,
// don't-care mask and overlap mode; emits a registered match pulse and match count.
module seq_pattern_detector
    import seq_pd_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             din_valid,
    input  logic             din,
    input  logic [LEN-1:0]   pattern,
    input  logic [LEN-1:0]   mask,
    input  logic             overlap,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [LEN-1:0]   window
);

    localparam int             FW        = fill_width(LEN);
    localparam bit             LEN_OK    = len_ok(LEN);
    localparam bit             CNT_W_OK  = cnt_w_ok(CNT_W);
    localparam logic [FW-1:0]  FILL_FULL = FW'(LEN);
    localparam logic [FW-1:0]  FILL_ONE  = FW'(1);

    if (!LEN_OK) begin : g_bad_len
        $error("seq_pattern_detector: LEN out of range");
    end
    if (!CNT_W_OK) begin : g_bad_cnt_w
        $error("seq_pattern_detector: CNT_W out of range");
    end

    logic [LEN-1:0] window_r;
    logic [FW-1:0]  fill_r;
    logic           match_r;
    logic [LEN-1:0] win_next_s;
    logic [FW-1:0]  fill_next_s;
    logic           hit_s;
    logic           inc_s;

    // Candidate next window/fill and the masked compare against the full window
    always_comb begin
        win_next_s = {window_r[LEN-2:0], din};
        if (fill_r == FILL_FULL) begin
            fill_next_s = FILL_FULL;
        end else begin
            fill_next_s = fill_r + FILL_ONE;
        end
        hit_s = (fill_next_s == FILL_FULL) &&
                (((win_next_s ^ pattern) & mask) == {LEN{1'b0}});
        inc_s = din_valid && !clear && hit_s;
    end

    // History, fill and match pulse; non-overlap mode restarts the fill on a hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window_r <= {LEN{1'b0}};
            fill_r   <= {FW{1'b0}};
            match_r  <= 1'b0;
        end else if (clear) begin
            window_r <= {LEN{1'b0}};
            fill_r   <= {FW{1'b0}};
            match_r  <= 1'b0;
        end else if (din_valid) begin
            window_r <= win_next_s;
            match_r  <= hit_s;
            if (hit_s && !overlap) begin
                fill_r <= {FW{1'b0}};
            end else begin
                fill_r <= fill_next_s;
            end
        end else begin
            window_r <= window_r;
            fill_r   <= fill_r;
            match_r  <= 1'b0;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (inc_s),
        .cnt   (match_count)
    );

    assign match  = match_r;
    assign window = window_r;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed, table-driven bench for seq_pattern_detector (LEN=4 with CNT_W=8 and CNT_W=2).
module tb_seq_pattern_detector;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       din_valid;
    logic       din;
    logic [3:0] pattern;
    logic [3:0] mask;
    logic       overlap;
    logic       match;
    logic [7:0] match_count;
    logic [3:0] window;

    logic       b_clear;
    logic       b_din_valid;
    logic       b_din;
    logic [3:0] b_pattern;
    logic [3:0] b_mask;
    logic       b_overlap;
    logic       b_match;
    logic [1:0] b_match_count;
    logic [3:0] b_window;

    int n_tests;
    int n_fail;

    typedef struct packed {
        logic       clr;
        logic       vld;
        logic       d;
        logic [3:0] pat;
        logic [3:0] msk;
        logic       ovl;
        logic       exp_m;
        logic [3:0] exp_w;
        logic [7:0] exp_c;
    } vec_t;

    vec_t vecs[$];

    seq_pattern_detector #(.LEN(4), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .din_valid   (din_valid),
        .din         (din),
        .pattern     (pattern),
        .mask        (mask),
        .overlap     (overlap),
        .match       (match),
        .match_count (match_count),
        .window      (window)
    );

    seq_pattern_detector #(.LEN(4), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .clear       (b_clear),
        .din_valid   (b_din_valid),
        .din         (b_din),
        .pattern     (b_pattern),
        .mask        (b_mask),
        .overlap     (b_overlap),
        .match       (b_match),
        .match_count (b_match_count),
        .window      (b_window)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic c, input logic v, input logic d, input logic [3:0] p,
                       input logic [3:0] m, input logic o, input logic em,
                       input logic [3:0] ew, input logic [7:0] ec);
        vec_t t;
        t.clr = c; t.vld = v; t.d = d; t.pat = p; t.msk = m; t.ovl = o;
        t.exp_m = em; t.exp_w = ew; t.exp_c = ec;
        vecs.push_back(t);
    endtask

    task automatic step_a(input logic c, input logic v, input logic d,
                          input logic [3:0] p, input logic [3:0] m, input logic o);
        clear = c; din_valid = v; din = d; pattern = p; mask = m; overlap = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; clear = 1'b0; din_valid = 1'b0; din = 1'b0;
        pattern = 4'b0000; mask = 4'b0000; overlap = 1'b0;
        b_clear = 1'b0; b_din_valid = 1'b0; b_din = 1'b0;
        b_pattern = 4'b1111; b_mask = 4'b1111; b_overlap = 1'b1;

        // Stream 1,0,1,1,0,1,1 with pattern 1011, overlapping
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b1, 1'b0,4'b0001,8'd0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b1111,1'b1, 1'b0,4'b0010,8'd0);
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b1, 1'b0,4'b0101,8'd0);
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b1, 1'b1,4'b1011,8'd1);
        add(1'b0,1'b1,1'b0,4'b1011,4'b1111,1'b1, 1'b0,4'b0110,8'd1);
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b1, 1'b0,4'b1101,8'd1);
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b1, 1'b1,4'b1011,8'd2);
        add(1'b1,1'b0,1'b0,4'b1011,4'b1111,1'b1, 1'b0,4'b0000,8'd0);
        // Same stream, non-overlapping
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b0, 1'b0,4'b0001,8'd0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b1111,1'b0, 1'b0,4'b0010,8'd0);
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b0, 1'b0,4'b0101,8'd0);
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b0, 1'b1,4'b1011,8'd1);
        add(1'b0,1'b1,1'b0,4'b1011,4'b1111,1'b0, 1'b0,4'b0110,8'd1);
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b0, 1'b0,4'b1101,8'd1);
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b0, 1'b0,4'b1011,8'd1);
        add(1'b1,1'b0,1'b0,4'b1011,4'b1111,1'b0, 1'b0,4'b0000,8'd0);
        // Gaps in din_valid: window holds, match stays low
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b1, 1'b0,4'b0001,8'd0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b1111,1'b1, 1'b0,4'b0010,8'd0);
        add(1'b0,1'b0,1'b1,4'b1011,4'b1111,1'b1, 1'b0,4'b0010,8'd0);
        add(1'b0,1'b0,1'b1,4'b1011,4'b1111,1'b1, 1'b0,4'b0010,8'd0);
        add(1'b0,1'b0,1'b1,4'b1011,4'b1111,1'b1, 1'b0,4'b0010,8'd0);
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b1, 1'b0,4'b0101,8'd0);
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b1, 1'b1,4'b1011,8'd1);
        add(1'b0,1'b0,1'b0,4'b1011,4'b1111,1'b1, 1'b0,4'b1011,8'd1);
        // Clear wins over a simultaneous valid bit
        add(1'b1,1'b1,1'b1,4'b1011,4'b1111,1'b1, 1'b0,4'b0000,8'd0);
        // Don't-care mask 1001, pattern 1001, non-overlapping: 1111 then 1011
        add(1'b0,1'b1,1'b1,4'b1001,4'b1001,1'b0, 1'b0,4'b0001,8'd0);
        add(1'b0,1'b1,1'b1,4'b1001,4'b1001,1'b0, 1'b0,4'b0011,8'd0);
        add(1'b0,1'b1,1'b1,4'b1001,4'b1001,1'b0, 1'b0,4'b0111,8'd0);
        add(1'b0,1'b1,1'b1,4'b1001,4'b1001,1'b0, 1'b1,4'b1111,8'd1);
        add(1'b0,1'b1,1'b1,4'b1001,4'b1001,1'b0, 1'b0,4'b1111,8'd1);
        add(1'b0,1'b1,1'b0,4'b1001,4'b1001,1'b0, 1'b0,4'b1110,8'd1);
        add(1'b0,1'b1,1'b1,4'b1001,4'b1001,1'b0, 1'b0,4'b1101,8'd1);
        add(1'b0,1'b1,1'b1,4'b1001,4'b1001,1'b0, 1'b1,4'b1011,8'd2);
        // Partial 1,0,1 then clear then 1: no match
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b0, 1'b0,4'b0111,8'd2);
        add(1'b0,1'b1,1'b0,4'b1011,4'b1111,1'b0, 1'b0,4'b1110,8'd2);
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b0, 1'b0,4'b1101,8'd2);
        add(1'b1,1'b0,1'b0,4'b1011,4'b1111,1'b0, 1'b0,4'b0000,8'd0);
        add(1'b0,1'b1,1'b1,4'b1011,4'b1111,1'b0, 1'b0,4'b0001,8'd0);
        // All don't-care: match once the window is full, back-to-back
        add(1'b0,1'b1,1'b0,4'b1011,4'b0000,1'b1, 1'b0,4'b0010,8'd0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b0000,1'b1, 1'b0,4'b0100,8'd0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b0000,1'b1, 1'b1,4'b1000,8'd1);
        add(1'b0,1'b1,1'b0,4'b1011,4'b0000,1'b1, 1'b1,4'b0000,8'd2);
        // Pattern changed between bits, history kept
        add(1'b0,1'b1,1'b1,4'b0001,4'b1111,1'b1, 1'b1,4'b0001,8'd3);

        #2;
        check("reset_match", {31'd0, match}, 32'd0);
        check("reset_window", {28'd0, window}, 32'd0);
        check("reset_count", {24'd0, match_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step_a(vecs[i].clr, vecs[i].vld, vecs[i].d, vecs[i].pat, vecs[i].msk, vecs[i].ovl);
            check($sformatf("vec%0d_match", i), {31'd0, match}, {31'd0, vecs[i].exp_m});
            check($sformatf("vec%0d_window", i), {28'd0, window}, {28'd0, vecs[i].exp_w});
            check($sformatf("vec%0d_count", i), {24'd0, match_count}, {24'd0, vecs[i].exp_c});
        end

        // Asynchronous reset mid-cycle clears everything before the next edge
        step_a(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("async_match", {31'd0, match}, 32'd0);
        check("async_window", {28'd0, window}, 32'd0);
        check("async_count", {24'd0, match_count}, 32'd0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        // After reset four fresh bits are needed even with an all-don't-care mask
        for (int k = 0; k < 4; k++) begin
            step_a(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
            check($sformatf("post_rst_match%0d", k), {31'd0, match}, (k == 3) ? 32'd1 : 32'd0);
        end
        check("post_rst_count", {24'd0, match_count}, 32'd1);

        // Saturating counter with CNT_W=2: eight ones, five pulses, count sticks at 3
        for (int k = 0; k < 8; k++) begin
            b_din_valid = 1'b1; b_din = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("sat_match%0d", k), {31'd0, b_match}, (k >= 3) ? 32'd1 : 32'd0);
            check($sformatf("sat_count%0d", k), {30'd0, b_match_count},
                  (k < 3) ? 32'd0 : ((k - 2 > 3) ? 32'd3 : 32'(k - 2)));
        end
        check("sat_window", {28'd0, b_window}, 32'd15);
        b_din_valid = 1'b0;
        @(posedge clk);
        #1;
        check("sat_idle_match", {31'd0, b_match}, 32'd0);
        check("sat_idle_count", {30'd0, b_match_count}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
